// File: rtl/mcu_pkg.sv
// Shared constants for the MCU data-RAM path: RAM geometry, port indices and
// the arbiter state encoding.
package mcu_pkg;
  localparam int RAM_AW = 8;
  localparam int RAM_DW = 16;

  localparam int P_CTRL = 0;
  localparam int P_EXT  = 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SETUP   = ST_SETUP,
    ACCESS  = ST_ACCESS,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } arb_state_e;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input request picker with one-hot grant. Round-robin by default;
// RAM_ARB_FIXED_PRIO_EN makes port 0 always win and removes the pointer.
module rr_arb2
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_in;
  assign unused_in = ^{clk, rst_n, upd};

  always_comb begin
    gnt = 2'b00;
    if (req[P_CTRL])     gnt[P_CTRL] = 1'b1;
    else if (req[P_EXT]) gnt[P_EXT]  = 1'b1;
  end
`else
  // last = port granted most recently; resets to 1 so port 0 wins the first tie
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last <= 1'b1;
    else if (upd && |req)   last <= gnt[P_EXT];
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Serialises port 0 (controller) and port 1 (loader) onto the single-port data
// RAM and sequences cs -> re/we -> capture. Tie policy set by RAM_ARB_FIXED_PRIO_EN.
module ram_arbiter
  import mcu_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          ram_cs,
  output logic          ram_re,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_out,
  input  logic [DW-1:0] ram_data_in
);

  arb_state_e    state, state_n;
  logic          cur, cur_n;
  logic          lat_we, lat_we_n;
  logic [AW-1:0] lat_addr, lat_addr_n;
  logic [DW-1:0] lat_wdata, lat_wdata_n;

  logic          gnt0_n, gnt1_n, done0_n, done1_n;
  logic          ram_cs_n, ram_re_n, ram_we_n;
  logic [AW-1:0] ram_addr_n;
  logic [DW-1:0] ram_data_out_n, rdata_n;
  logic [1:0]    pick;

  rr_arb2 u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .upd   (state == IDLE),
    .gnt   (pick)
  );

  // Every output is a register: the combinational block computes next values,
  // so each strobe appears one clock after the state that requests it.
  always_comb begin
    state_n        = state;
    cur_n          = cur;
    lat_we_n       = lat_we;
    lat_addr_n     = lat_addr;
    lat_wdata_n    = lat_wdata;
    gnt0_n         = gnt0;
    gnt1_n         = gnt1;
    done0_n        = 1'b0;
    done1_n        = 1'b0;
    ram_cs_n       = ram_cs;
    ram_re_n       = ram_re;
    ram_we_n       = ram_we;
    ram_addr_n     = ram_addr;
    ram_data_out_n = ram_data_out;
    rdata_n        = rdata;
    case (state)
      IDLE: begin
        if (|pick) begin
          cur_n       = pick[P_EXT];
          lat_we_n    = pick[P_EXT] ? we1    : we0;
          lat_addr_n  = pick[P_EXT] ? addr1  : addr0;
          lat_wdata_n = pick[P_EXT] ? wdata1 : wdata0;
          gnt0_n      = pick[P_CTRL];
          gnt1_n      = pick[P_EXT];
          state_n     = SETUP;
        end
      end
      SETUP: begin
        ram_cs_n   = 1'b1;
        ram_addr_n = lat_addr;
        if (lat_we) ram_data_out_n = lat_wdata;
        state_n    = ACCESS;
      end
      ACCESS: begin
        ram_we_n = lat_we;
        ram_re_n = !lat_we;
        state_n  = CAPTURE;
      end
      CAPTURE: begin
        ram_re_n = 1'b0;
        ram_we_n = 1'b0;
        if (!lat_we) rdata_n = ram_data_in;
        state_n  = DONE;
      end
      DONE: begin
        done0_n  = !cur;
        done1_n  = cur;
        ram_cs_n = 1'b0;
        gnt0_n   = 1'b0;
        gnt1_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      ram_cs       <= 1'b0;
      ram_re       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      rdata        <= '0;
    end else begin
      state        <= state_n;
      cur          <= cur_n;
      lat_we       <= lat_we_n;
      lat_addr     <= lat_addr_n;
      lat_wdata    <= lat_wdata_n;
      gnt0         <= gnt0_n;
      gnt1         <= gnt1_n;
      done0        <= done0_n;
      done1        <= done1_n;
      ram_cs       <= ram_cs_n;
      ram_re       <= ram_re_n;
      ram_we       <= ram_we_n;
      ram_addr     <= ram_addr_n;
      ram_data_out <= ram_data_out_n;
      rdata        <= rdata_n;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: per-port expected queues filled when a
// request is driven, drained on each done pulse.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, done0, gnt1, done1, ram_cs, ram_re, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] rdata, ram_data_out, ram_data_in;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .ram_cs(ram_cs), .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
  );

  // RAM macro model: asynchronous read, write on the clock edge
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  assign ram_data_in = mem[ram_addr];
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data_out;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q0[$], q1[$];
  int   gnt_log[$];
  int   cyc = 0, gcyc0 = 0, gcyc1 = 0, dcyc1 = 0, stb_len = 0;
  logic gnt0_q = 1'b0, gnt1_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic on_done(input int p);
    exp_t e;
    int   sz;
    sz = (p == 0) ? q0.size() : q1.size();
    chk("sb_pending", sz > 0, 1);
    if (sz > 0) begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk(p == 0 ? "lat0" : "lat1", cyc - (p == 0 ? gcyc0 : gcyc1), 4);
      if (!e.we) chk(p == 0 ? "rdata0" : "rdata1", rdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      gnt0_q = 1'b0;
      gnt1_q = 1'b0;
      stb_len = 0;
    end else begin
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("strobe_excl", ram_re & ram_we, 0);
      if (gnt0 && !gnt0_q) begin gcyc0 = cyc; gnt_log.push_back(0); end
      if (gnt1 && !gnt1_q) begin gcyc1 = cyc; gnt_log.push_back(1); end
      if (ram_re || ram_we) begin
        stb_len++;
        if (gnt0 && q0.size() > 0) begin
          chk("stb_dir0", ram_we, q0[0].we);
          chk("stb_addr0", ram_addr, q0[0].addr);
        end
        if (gnt1 && q1.size() > 0) begin
          chk("stb_dir1", ram_we, q1[0].we);
          chk("stb_addr1", ram_addr, q1[0].addr);
        end
      end else if (stb_len > 0) begin
        chk("stb_len", stb_len, 1);
        stb_len = 0;
      end
      if (done0) on_done(0);
      if (done1) begin dcyc1 = cyc; on_done(1); end
      gnt0_q = gnt0;
      gnt1_q = gnt1;
    end
  end

  // Called on a falling edge; returns on the falling edge where done is seen.
  task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    e.we   = w;
    e.addr = a;
    e.data = w ? d : ref_mem[a];
    if (w) ref_mem[a] = d;
    if (p == 0) begin q0.push_back(e); we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin q1.push_back(e); we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? done0 : done1;
    end
    chk(p == 0 ? "txn_done0" : "txn_done1", seen, 1);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[4];
    bit seen;

    @(negedge clk);
    chk("rst_ctrl", {gnt0, gnt1, done0, done1, ram_cs, ram_re, ram_we}, 0);
    chk("rst_data", {ram_addr, ram_data_out, rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // simultaneous requests straight out of reset, both re-requesting
    gnt_log.delete();
    fork
      begin txn(0, 1'b1, 8'h40, 16'h4000); txn(0, 1'b1, 8'h41, 16'h4001); end
      begin txn(1, 1'b1, 8'h50, 16'h5000); txn(1, 1'b1, 8'h51, 16'h5001); end
    join
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    chk("order_len", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("grant_order", gnt_log[i], exp_order[i]);

    // single write then read on port 0
    txn(0, 1'b1, 8'h10, 16'hA5A5);
    txn(0, 1'b0, 8'h10, 16'h0000);
    chk("rd_a5a5", rdata, 16'hA5A5);

    // top address is an ordinary location
    txn(1, 1'b1, 8'hFF, 16'hC3C3);
    txn(1, 1'b0, 8'hFF, 16'h0000);

    // port 1 read while port 0 arrives mid-transaction
    txn(1, 1'b1, 8'h20, 16'h1234);
    fork
      begin
        txn(1, 1'b0, 8'h20, 16'h0000);
        chk("rd_1234", rdata, 16'h1234);
      end
      begin
        repeat (3) @(negedge clk);
        txn(0, 1'b0, 8'h10, 16'h0000);
      end
    join
    chk("gnt0_after_done1", gcyc0 - dcyc1, 1);

    // a write leaves rdata alone
    txn(0, 1'b1, 8'h01, 16'h00FF);
    txn(0, 1'b0, 8'h01, 16'h0000);
    fork
      txn(1, 1'b1, 8'h02, 16'hBEEF);
      repeat (4) begin @(negedge clk); chk("rdata_hold", rdata, 16'h00FF); end
    join
    chk("rdata_after_wr", rdata, 16'h00FF);

    // reset in the middle of a write
    we0 = 1'b1; addr0 = 8'h30; wdata0 = 16'h3333; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ram_we;
    end
    chk("we_reached", seen, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_abort", {ram_we, ram_re, ram_cs, gnt0, gnt1, done0, done1}, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    fork
      txn(0, 1'b0, 8'h40, 16'h0000);
      txn(1, 1'b0, 8'h50, 16'h0000);
    join
    chk("tie_len", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("tie_after_rst", gnt_log[0], 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
